// File: rtl/prbs8_pkg.sv
// Shared definitions for the 8-bit Fibonacci PRBS (x^8+x^6+x^5+x^4+1)
// used by both the generator and the receive-side checker.
package prbs8_pkg;

    localparam logic [2:0] TAPS [4] = '{3'd7, 3'd5, 3'd4, 3'd3};

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_e;

    function automatic logic prbs8_next(input logic [7:0] s);
        return s[TAPS[0]] ^ s[TAPS[1]] ^ s[TAPS[2]] ^ s[TAPS[3]];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; a clear that
// coincides with an increment leaves the count at one.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = inc_i ? WIDTH'(1) : '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/prbs8_checker.sv
// Self-synchronising PRBS8 checker: fills, verifies, locks, then counts
// bit errors against the free-running prediction.
module prbs8_checker
    import prbs8_pkg::state_e;
    import prbs8_pkg::prbs8_next;
#(
    parameter int unsigned LOCK_COUNT = 16,
    parameter int unsigned LOSS_COUNT = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 I,
    input  logic                 I_VALID,
    input  logic                 CLEAR,
    output logic                 LOCKED,
    output logic                 ERR,
    output logic [CNT_WIDTH-1:0] ERR_COUNT
);

    localparam logic [7:0] MATCH_LAST = 8'(LOCK_COUNT - 1);
    localparam logic [3:0] LOSS_LAST  = 4'(LOSS_COUNT - 1);

    state_e     state_q, state_d;
    logic [7:0] s_q, s_d;
    logic [3:0] fill_q, fill_d;
    logic [7:0] match_q, match_d;
    logic [3:0] loss_q, loss_d;
    logic       locked_q;
    logic       err_q, err_d;
    logic       p;
    logic       count_inc;

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        fill_d    = fill_q;
        match_d   = match_q;
        loss_d    = loss_q;
        err_d     = 1'b0;
        count_inc = 1'b0;
        p         = prbs8_next(s_q);
        if (I_VALID) begin
            case (state_q)
                prbs8_pkg::SEARCH: begin
                    s_d    = {s_q[6:0], I};
                    fill_d = fill_q + 4'd1;
                    if (fill_q == 4'd7) begin
                        state_d = prbs8_pkg::VERIFY;
                        match_d = '0;
                    end
                end
                prbs8_pkg::VERIFY: begin
                    s_d = {s_q[6:0], I};
                    // all-zero history is a dead state of the generator, never a match
                    if ((I == p) && (s_q != '0)) begin
                        match_d = match_q + 8'd1;
                        if (match_q == MATCH_LAST) begin
                            state_d = prbs8_pkg::LOCKED;
                            loss_d  = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                prbs8_pkg::LOCKED: begin
                    // free-run on the prediction so a single line error counts once
                    s_d = {s_q[6:0], p};
                    if (I != p) begin
                        err_d     = 1'b1;
                        count_inc = 1'b1;
                        loss_d    = loss_q + 4'd1;
                        if (loss_q == LOSS_LAST) begin
                            state_d = prbs8_pkg::SEARCH;
                            fill_d  = '0;
                        end
                    end else begin
                        loss_d = '0;
                    end
                end
                default: begin
                    state_d = prbs8_pkg::SEARCH;
                    fill_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= prbs8_pkg::SEARCH;
            s_q      <= '0;
            fill_q   <= '0;
            match_q  <= '0;
            loss_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            fill_q   <= fill_d;
            match_q  <= match_d;
            loss_q   <= loss_d;
            locked_q <= (state_d == prbs8_pkg::LOCKED);
            err_q    <= err_d;
        end
    end

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_err_cnt (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .inc_i  (count_inc),
        .clr_i  (CLEAR),
        .count_o(ERR_COUNT)
    );

    assign LOCKED = locked_q;
    assign ERR    = err_q;

endmodule

// File: tb/tb_prbs8_checker.sv
// Directed bench for prbs8_checker: a wide-counter and a 2-bit-counter
// instance share one stimulus stream and are checked against a bit-history model.
module tb_prbs8_checker;

    localparam int LOCK_N = 16;
    localparam int LOSS_N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_bit, in_valid, clr;
    logic        locked_a, err_a, locked_b, err_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] g;

    prbs8_checker #(
        .LOCK_COUNT(LOCK_N),
        .LOSS_COUNT(LOSS_N),
        .CNT_WIDTH (16)
    ) dut_a (
        .CLK      (clk),
        .RESET    (rst),
        .I        (in_bit),
        .I_VALID  (in_valid),
        .CLEAR    (clr),
        .LOCKED   (locked_a),
        .ERR      (err_a),
        .ERR_COUNT(cnt_a)
    );

    prbs8_checker #(
        .LOCK_COUNT(LOCK_N),
        .LOSS_COUNT(LOSS_N),
        .CNT_WIDTH (2)
    ) dut_b (
        .CLK      (clk),
        .RESET    (rst),
        .I        (in_bit),
        .I_VALID  (in_valid),
        .CLEAR    (clr),
        .LOCKED   (locked_b),
        .ERR      (err_b),
        .ERR_COUNT(cnt_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: the line bits the checker believes in, oldest first.
    // mode 0 = acquiring, 1 = verifying, 2 = locked.
    int m_mode;
    bit hist[$];
    int m_run, m_loss, m_cnt;
    bit m_err;
    bit m_ready = 1'b0;

    always @(posedge clk) begin
        bit pred;
        int ones;
        if (rst) begin
            m_mode = 0;
            hist.delete();
            m_run  = 0;
            m_loss = 0;
            m_cnt  = 0;
            m_err  = 1'b0;
            m_ready = 1'b1;
        end else begin
            m_err = 1'b0;
            if (clr) m_cnt = 0;
            if (in_valid) begin
                if (m_mode == 0) begin
                    hist.push_back(in_bit);
                    if (hist.size() == 8) begin
                        m_mode = 1;
                        m_run  = 0;
                    end
                end else begin
                    // b[n] = b[n-8] ^ b[n-6] ^ b[n-5] ^ b[n-4]
                    pred = hist[0] ^ hist[2] ^ hist[3] ^ hist[4];
                    ones = 0;
                    foreach (hist[k]) ones += int'(hist[k]);
                    if (m_mode == 1) begin
                        hist.push_back(in_bit);
                        void'(hist.pop_front());
                        if ((in_bit == pred) && (ones != 0)) begin
                            m_run++;
                            if (m_run == LOCK_N) begin
                                m_mode = 2;
                                m_loss = 0;
                            end
                        end else begin
                            m_run = 0;
                        end
                    end else begin
                        hist.push_back(pred);
                        void'(hist.pop_front());
                        if (in_bit != pred) begin
                            m_err = 1'b1;
                            m_cnt++;
                            m_loss++;
                            if (m_loss == LOSS_N) begin
                                m_mode = 0;
                                hist.delete();
                            end
                        end else begin
                            m_loss = 0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            check("m_locked_a", 32'(locked_a), 32'(m_mode == 2));
            check("m_err_a",    32'(err_a),    32'(m_err));
            check("m_cnt_a",    32'(cnt_a),    32'((m_cnt > 65535) ? 65535 : m_cnt));
            check("m_locked_b", 32'(locked_b), 32'(m_mode == 2));
            check("m_err_b",    32'(err_b),    32'(m_err));
            check("m_cnt_b",    32'(cnt_b),    32'((m_cnt > 3) ? 3 : m_cnt));
        end
    end

    task automatic step(input logic b, input logic v, input logic c);
        rst      = 1'b0;
        in_bit   = b;
        in_valid = v;
        clr      = c;
        @(negedge clk);
    endtask

    task automatic gen_next(output logic b);
        b = g[7] ^ g[5] ^ g[4] ^ g[3];
        g = {g[6:0], b};
    endtask

    task automatic clean(input int n);
        logic b;
        for (int k = 0; k < n; k++) begin
            gen_next(b);
            step(b, 1'b1, 1'b0);
        end
    endtask

    task automatic bad(input logic c);
        logic b;
        gen_next(b);
        step(~b, 1'b1, c);
    endtask

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog: run exceeded time limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        logic b;
        rst      = 1'b1;
        in_bit   = 1'b0;
        in_valid = 1'b0;
        clr      = 1'b0;
        g        = 8'h01;
        repeat (3) @(negedge clk);
        check("rst_locked", 32'(locked_a), 32'd0);
        check("rst_err",    32'(err_a),    32'd0);
        check("rst_cnt_a",  32'(cnt_a),    32'd0);
        check("rst_cnt_b",  32'(cnt_b),    32'd0);

        clean(23);
        check("lock_bit23", 32'(locked_a), 32'd0);
        clean(1);
        check("lock_bit24_a", 32'(locked_a), 32'd1);
        check("lock_bit24_b", 32'(locked_b), 32'd1);

        clean(1000);
        check("clean_cnt", 32'(cnt_a), 32'd0);

        bad(1'b0);
        check("single_err",    32'(err_a),    32'd1);
        check("single_cnt",    32'(cnt_a),    32'd1);
        check("single_locked", 32'(locked_a), 32'd1);
        clean(1);
        check("err_pulse_end", 32'(err_a), 32'd0);

        clean(10);
        gen_next(b);
        step(b, 1'b1, 1'b1);
        check("clear_cnt", 32'(cnt_a), 32'd0);

        repeat (3) bad(1'b0);
        check("burst3_locked", 32'(locked_a), 32'd1);
        bad(1'b0);
        check("burst4_locked", 32'(locked_a), 32'd0);
        check("burst4_err",    32'(err_a),    32'd1);
        check("burst4_cnt_a",  32'(cnt_a),    32'd4);
        check("burst4_cnt_b",  32'(cnt_b),    32'd3);

        clean(23);
        check("relock_bit23", 32'(locked_a), 32'd0);
        clean(1);
        check("relock_bit24", 32'(locked_a), 32'd1);

        for (int k = 0; k < 200; k++) begin
            if ((k % 2) == 0) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            else clean(1);
        end
        check("gap_locked", 32'(locked_a), 32'd1);
        check("gap_cnt",    32'(cnt_a),    32'd4);

        bad(1'b1);
        check("clr_err_cnt_a", 32'(cnt_a), 32'd1);
        check("clr_err_cnt_b", 32'(cnt_b), 32'd1);
        check("clr_err_err",   32'(err_a), 32'd1);

        for (int k = 0; k < 5; k++) begin
            bad(1'b0);
            clean(6);
        end
        check("iso_cnt_a",  32'(cnt_a),    32'd6);
        check("iso_cnt_b",  32'(cnt_b),    32'd3);
        check("iso_locked", 32'(locked_a), 32'd1);

        gen_next(b);
        rst      = 1'b1;
        in_bit   = ~b;
        in_valid = 1'b1;
        clr      = 1'b0;
        @(negedge clk);
        check("midrst_locked", 32'(locked_a), 32'd0);
        check("midrst_err",    32'(err_a),    32'd0);
        check("midrst_cnt_a",  32'(cnt_a),    32'd0);
        check("midrst_cnt_b",  32'(cnt_b),    32'd0);

        for (int k = 0; k < 100; k++) begin
            step(1'b0, 1'b1, 1'b0);
            check("zero_nolock", 32'(locked_a), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
